// File: rtl/register_file_ras.sv
// Decode-stage register file: two combinational read ports with optional
// same-cycle write forwarding, hardwired-zero R0, and a circular
// return-address stack that serves CALL/RET.
module register_file_ras #(
    parameter int REG_WIDTH  = 3,
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 16,
    parameter int LINK_REG   = 7,
    parameter int RAS_DEPTH  = 4,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REG_WIDTH-1:0]           rs1,
    input  logic [REG_WIDTH-1:0]           rs2,
    input  logic [REG_WIDTH-1:0]           rd,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           reg_write,
    input  logic                           call,
    input  logic                           ret,
    input  logic [PC_WIDTH-1:0]            call_pc,
    output logic [DATA_WIDTH-1:0]          read_data1,
    output logic [DATA_WIDTH-1:0]          read_data2,
    output logic [PC_WIDTH-1:0]            ret_pc,
    output logic                           ret_valid,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int NUM_REGS = 2 ** REG_WIDTH;
    localparam int PTR_W    = $clog2(RAS_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] link_data;
    logic                  wr_active;

    logic [PC_WIDTH-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      top_reg;
    logic [PTR_W-1:0]      top_inc;
    logic [PTR_W-1:0]      top_dec;
    logic [CNT_W-1:0]      count_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  non_empty;
    logic                  full;

    // Return address resized to the register width for the link write.
    generate
        if (PC_WIDTH >= DATA_WIDTH) begin : g_link_trunc
            assign link_data = call_pc[DATA_WIDTH-1:0];
        end else begin : g_link_zext
            assign link_data = {{(DATA_WIDTH-PC_WIDTH){1'b0}}, call_pc};
        end
    endgenerate

    // A write to R0 is never performed and never forwarded.
    assign wr_active = reg_write && (rd != '0);

    // Register array: link write first so a same-cycle reg_write to the link register wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (call) begin
                regs[REG_WIDTH'(LINK_REG)] <= link_data;
            end
            if (wr_active) begin
                regs[rd] <= write_data;
            end
        end
    end

    // Read ports; only write-back data is forwarded, never the link value.
    generate
        if (BYPASS != 0) begin : g_bypass
            assign read_data1 = (wr_active && rd == rs1) ? write_data : regs[rs1];
            assign read_data2 = (wr_active && rd == rs2) ? write_data : regs[rs2];
        end else begin : g_no_bypass
            assign read_data1 = regs[rs1];
            assign read_data2 = regs[rs2];
        end
    endgenerate

    assign top_inc   = top_reg + PTR_W'(1);
    assign top_dec   = top_reg - PTR_W'(1);
    assign non_empty = (count_reg != '0);
    assign full      = (count_reg == CNT_W'(RAS_DEPTH));

    // Return-address stack: top pointer addresses the most recent entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
            top_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (call && ret && non_empty) begin
            // Return and re-call in one cycle: swap the top in place.
            ras_mem[top_reg] <= call_pc;
        end else if (call) begin
            // Push; when full the slot after top is the oldest entry.
            ras_mem[top_inc] <= call_pc;
            top_reg          <= top_inc;
            if (full) begin
                overflow_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
            if (ret) begin
                underflow_reg <= 1'b1;
            end
        end else if (ret) begin
            if (non_empty) begin
                top_reg   <= top_dec;
                count_reg <= count_reg - CNT_W'(1);
            end else begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign ret_pc        = non_empty ? ras_mem[top_reg] : '0;
    assign ret_valid     = ret && non_empty;
    assign ras_count     = count_reg;
    assign ras_empty     = !non_empty;
    assign ras_full      = full;
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;

endmodule

// File: tb/tb_register_file_ras.sv
// Scoreboard bench for register_file_ras: stimulus queues expected values
// tagged with the cycle they apply to; a monitor compares them mid-cycle.
module tb_register_file_ras;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rs1, rs2, rd;
    logic [15:0] write_data;
    logic        reg_write, call, ret;
    logic [15:0] call_pc;
    logic [15:0] read_data1, read_data2, ret_pc;
    logic        ret_valid;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    register_file_ras dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
        .write_data(write_data), .reg_write(reg_write),
        .call(call), .ret(ret), .call_pc(call_pc),
        .read_data1(read_data1), .read_data2(read_data2),
        .ret_pc(ret_pc), .ret_valid(ret_valid), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    localparam int K_RD1 = 0, K_RD2 = 1, K_RETPC = 2, K_RETV = 3, K_CNT = 4,
                   K_EMPTY = 5, K_FULL = 6, K_OVF = 7, K_UNF = 8;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_RD1:   return "read_data1";
            K_RD2:   return "read_data2";
            K_RETPC: return "ret_pc";
            K_RETV:  return "ret_valid";
            K_CNT:   return "ras_count";
            K_EMPTY: return "ras_empty";
            K_FULL:  return "ras_full";
            K_OVF:   return "ras_overflow";
            default: return "ras_underflow";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_RD1:   return 32'(read_data1);
            K_RD2:   return 32'(read_data2);
            K_RETPC: return 32'(ret_pc);
            K_RETV:  return 32'(ret_valid);
            K_CNT:   return 32'(ras_count);
            K_EMPTY: return 32'(ras_empty);
            K_FULL:  return 32'(ras_full);
            K_OVF:   return 32'(ras_overflow);
            default: return 32'(ras_underflow);
        endcase
    endfunction

    // Monitor: mid-cycle, pop every expectation tagged with this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = exp_q.pop_front();
            a = actual(e.kind);
            checks = checks + 1;
            if (e.cyc != cyc) begin
                failures = failures + 1;
                $display("FAIL %s stale expectation cycle=%0d now=%0d", kname(e.kind), e.cyc, cyc);
            end else if (a !== e.val) begin
                failures = failures + 1;
                $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", kname(e.kind), cyc, a, e.val);
            end else begin
                $display("ok   %s cycle=%0d value=0x%0h", kname(e.kind), cyc, a);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Advance to the next cycle and return all strobes to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0; reg_write = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        tick();
    endtask

    task automatic expect_flags(input int cnt, input int emp, input int ful, input int ovf, input int unf);
        expect_val(K_CNT, 32'(cnt));
        expect_val(K_EMPTY, 32'(emp));
        expect_val(K_FULL, 32'(ful));
        expect_val(K_OVF, 32'(ovf));
        expect_val(K_UNF, 32'(unf));
    endtask

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; write_data = '0;
        reg_write = 1'b0; call = 1'b0; ret = 1'b0; call_pc = '0;
        @(posedge clk);
        do_reset();

        // Reset state
        rs1 = 3'd5; rs2 = 3'd7;
        expect_flags(0, 1, 0, 0, 0);
        expect_val(K_RD1, 32'h0);
        expect_val(K_RETPC, 32'h0);
        expect_val(K_RETV, 32'h0);

        // Write r3 with same-cycle bypass, then persistent value
        tick();
        reg_write = 1'b1; rd = 3'd3; write_data = 16'hABCD; rs1 = 3'd3; rs2 = 3'd2;
        expect_val(K_RD1, 32'hABCD);
        expect_val(K_RD2, 32'h0);
        tick();
        rs1 = 3'd3;
        expect_val(K_RD1, 32'hABCD);

        // Write to R0 is discarded and not forwarded
        tick();
        reg_write = 1'b1; rd = 3'd0; write_data = 16'h1234; rs1 = 3'd0;
        expect_val(K_RD1, 32'h0);
        tick();
        rs2 = 3'd0;
        expect_val(K_RD2, 32'h0);

        // Three pushes; link write is not forwarded during the call cycle
        tick();
        call = 1'b1; call_pc = 16'h0010; rs2 = 3'd7;
        expect_val(K_RD2, 32'h0);
        tick();
        call = 1'b1; call_pc = 16'h0020;
        tick();
        call = 1'b1; call_pc = 16'h0030;
        tick();
        rs1 = 3'd7;
        expect_val(K_RD1, 32'h0030);
        expect_val(K_CNT, 32'd3);

        // Three pops in LIFO order
        ret = 1'b1;
        expect_val(K_RETPC, 32'h0030); expect_val(K_RETV, 32'h1); expect_val(K_CNT, 32'd3);
        tick();
        ret = 1'b1;
        expect_val(K_RETPC, 32'h0020); expect_val(K_RETV, 32'h1); expect_val(K_CNT, 32'd2);
        tick();
        ret = 1'b1;
        expect_val(K_RETPC, 32'h0010); expect_val(K_RETV, 32'h1); expect_val(K_CNT, 32'd1);
        tick();
        expect_flags(0, 1, 0, 0, 0);
        expect_val(K_RETPC, 32'h0);

        // Overflow: five pushes into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            tick();
            call = 1'b1; call_pc = 16'(i * 16'h0100);
            if (i == 5) begin
                expect_flags(4, 0, 1, 0, 0);
            end
        end
        tick();
        expect_flags(4, 0, 1, 1, 0);
        for (int i = 5; i >= 2; i--) begin
            ret = 1'b1;
            expect_val(K_RETPC, 32'(i * 32'h0100));
            expect_val(K_RETV, 32'h1);
            tick();
        end
        expect_flags(0, 1, 0, 1, 0);

        // Underflow on empty after reset
        tick();
        do_reset();
        ret = 1'b1;
        expect_val(K_RETV, 32'h0);
        expect_val(K_RETPC, 32'h0);
        tick();
        expect_flags(0, 1, 0, 0, 1);

        // Simultaneous call and ret with one entry: in-place replace
        call = 1'b1; call_pc = 16'h0040;
        tick();
        call = 1'b1; ret = 1'b1; call_pc = 16'h0077;
        expect_val(K_RETPC, 32'h0040);
        expect_val(K_RETV, 32'h1);
        tick();
        expect_val(K_CNT, 32'd1);
        ret = 1'b1;
        expect_val(K_RETPC, 32'h0077);
        expect_val(K_RETV, 32'h1);
        tick();
        expect_val(K_CNT, 32'd0);

        // Simultaneous call and ret on empty: underflow plus normal push
        call = 1'b1; ret = 1'b1; call_pc = 16'h0ABC;
        expect_val(K_RETV, 32'h0);
        tick();
        expect_val(K_CNT, 32'd1);
        expect_val(K_RETPC, 32'h0ABC);

        // call and reg_write to link register: write-back data wins
        call = 1'b1; call_pc = 16'h0099; reg_write = 1'b1; rd = 3'd7; write_data = 16'h5555;
        tick();
        rs1 = 3'd7;
        expect_val(K_RD1, 32'h5555);
        expect_val(K_RETPC, 32'h0099);
        expect_val(K_CNT, 32'd2);

        // Reset mid-stack clears everything; next ret underflows
        tick();
        do_reset();
        rs1 = 3'd7; rs2 = 3'd3;
        expect_flags(0, 1, 0, 0, 0);
        expect_val(K_RD1, 32'h0);
        expect_val(K_RD2, 32'h0);
        ret = 1'b1;
        expect_val(K_RETV, 32'h0);
        tick();
        expect_val(K_UNF, 32'h1);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_ras.md
Name: register_file_ras

Overview:
Parametrised successor to the pipeline's 8x16 register file. Provides two combinational read ports with optional write-to-read bypass, a hardwired-zero R0, and a dedicated hardware return-address stack (RAS) that replaces the single link-register mechanism for CALL/RET. Sits in the decode stage; the write port is driven from write-back, and CALL/RET strobes come from decode.

Parameters:
REG_WIDTH, 3, register index width; NUM_REGS = 2**REG_WIDTH
DATA_WIDTH, 16, register data width
PC_WIDTH, 16, program-counter width
LINK_REG, 7, register that also receives the return address on CALL
RAS_DEPTH, 4, return-stack entries; power of two, at least 2
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rs1  in  REG_WIDTH  read index 1
rs2  in  REG_WIDTH  read index 2
rd  in  REG_WIDTH  write index
write_data  in  DATA_WIDTH  write-back data
reg_write  in  1  write enable
call  in  1  CALL strobe: push call_pc
ret  in  1  RET strobe: pop
call_pc  in  PC_WIDTH  return address to push
read_data1  out  DATA_WIDTH  combinational read of rs1
read_data2  out  DATA_WIDTH  combinational read of rs2
ret_pc  out  PC_WIDTH  top of stack, valid when ret_valid
ret_valid  out  1  ret asserted and stack non-empty (combinational)
ras_count  out  clog2(RAS_DEPTH)+1  current number of entries
ras_empty  out  1  ras_count == 0
ras_full  out  1  ras_count == RAS_DEPTH
ras_overflow  out  1  sticky; set when a push discards the oldest entry
ras_underflow  out  1  sticky; set when ret is asserted while empty

Behaviour:
- Reset (rst high at a clock edge): all registers = 0; stack pointer = 0; ras_count = 0; both sticky flags = 0. rst has priority over every other input.
- R0: reads always return 0; writes to R0 are discarded.
- Register write: when reg_write is 1 and rd != 0, regs[rd] <= write_data at the clock edge.
- Link write: when call is 1, regs[LINK_REG] <= call_pc, zero-extended or truncated to DATA_WIDTH. If reg_write is 1 with rd == LINK_REG in the same cycle, the reg_write data wins.
- Reads are combinational from the register array.
- Bypass (BYPASS = 1): if reg_write is 1, rd != 0 and rd == rsN, then read_data N = write_data. The link write is not bypassed.
- With BYPASS = 0, the new value is visible the cycle after the write.
- RAS storage: circular buffer with a top pointer.
- ret_pc = entry at top when ras_count > 0, otherwise 0.
- ret_valid = ret & (ras_count > 0).
- Push only (call=1, ret=0):
  - Write entry at top+1 and advance the pointer modulo RAS_DEPTH.
  - If not full, ras_count increments.
  - If full, the oldest entry is overwritten, ras_count stays at RAS_DEPTH and ras_overflow is set.
- Pop only (call=0, ret=1):
  - If non-empty, the pointer decrements modulo RAS_DEPTH and ras_count decrements.
  - If empty, there is no state change except setting ras_underflow.
- Simultaneous call and ret:
  - If non-empty, ret_pc reports the current top. The top entry is then replaced in place by call_pc; pointer and count are unchanged.
  - If empty, ras_underflow is set, ret_valid = 0, and a normal push is performed (count becomes 1).
- Sticky flags clear only on rst.
- Reset asserted mid-sequence discards all stack contents; the next ret after reset underflows.

Test Plan:
1. Reset, then write r3=0xABCD with BYPASS=1 and rs1=3 in the same cycle -> read_data1=0xABCD that cycle; next cycle still 0xABCD. Write r0=0x1234 -> read of r0 = 0x0000.
2. Push 0x0010, 0x0020, 0x0030 in successive cycles, then ret x3 -> ret_pc 0x0030, 0x0020, 0x0010 with ret_valid=1 each time; ras_count goes 3,2,1,0; ras_empty=1 at the end.
3. Push 5 entries 0x0100..0x0500 with RAS_DEPTH=4 -> ras_full=1, ras_overflow=1, ras_count=4; pops return 0x0500, 0x0400, 0x0300, 0x0200, then empty.
4. ret on empty after reset -> ret_valid=0, ret_pc=0, ras_underflow=1, ras_count=0.
5. Stack holds [0x0040]; assert call=1, ret=1, call_pc=0x0077 -> ret_pc=0x0040 that cycle; ras_count stays 1; next ret returns 0x0077.
6. call with call_pc=0x0099 plus reg_write rd=7 data=0x5555 in the same cycle -> r7=0x5555, RAS top=0x0099; then rst mid-stack -> ras_count=0, flags cleared, r7=0.
